// File: rtl/alu_seq_muldiv_pkg.sv
// alu_seq_muldiv shared definitions:
// opcodes, status bit positions, FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1001;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  localparam int ST_ZERO  = 0;
  localparam int ST_NEG   = 1;
  localparam int ST_CARRY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_DIVZ  = 4;
  localparam int ST_ILL   = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_muldiv_if.sv
// alu_seq_muldiv request/response bundle:
// master = issuing stage, slave = ALU.
interface alu_seq_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALU_ctrl;
  logic [WIDTH-1:0] ALU_operand_1;
  logic [WIDTH-1:0] ALU_operand_2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_result;
  logic [WIDTH-1:0] ALU_result_hi;
  logic [7:0]       ALU_status;

  modport master (
    output in_valid, ALU_ctrl,
    output ALU_operand_1, ALU_operand_2,
    output out_ready,
    input  in_ready, out_valid,
    input  ALU_result, ALU_result_hi,
    input  ALU_status
  );

  modport slave (
    input  in_valid, ALU_ctrl,
    input  ALU_operand_1, ALU_operand_2,
    input  out_ready,
    output in_ready, out_valid,
    output ALU_result, ALU_result_hi,
    output ALU_status
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide,
// one bit per cycle; o_done flags the final step.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_div;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sh;
  logic             w_borrow;
  logic [WIDTH-1:0] w_hi_n;
  logic [WIDTH-1:0] w_lo_n;

  // next partial state: hi:lo is product or rem:quot
  always_comb begin
    w_add = {1'b0, r_hi}
          + (r_lo[0] ? {1'b0, r_b}
                     : {(WIDTH+1){1'b0}});
    w_sh = {r_hi, r_lo[WIDTH-1]};
    w_borrow = w_sh < {1'b0, r_b};
    if (r_div) begin
      w_hi_n = w_borrow ? w_sh[WIDTH-1:0]
                        : w_sh[WIDTH-1:0] - r_b;
      w_lo_n = {r_lo[WIDTH-2:0], ~w_borrow};
    end else begin
      w_hi_n = w_add[WIDTH:1];
      w_lo_n = {w_add[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));
  assign o_lo   = w_lo_n;
  assign o_hi   = w_hi_n;

  // load on start, then step until the count runs out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_div <= 1'b0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CNT_W'(WIDTH);
      r_div <= i_div;
      r_b   <= i_b;
      r_hi  <= '0;
      r_lo  <= i_a;
    end else if (r_cnt != '0) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/alu_seq_muldiv.sv
// Handshaked ALU: single-cycle logic/arith ops plus
// iterative MULTU/DIVU, registered result and flags.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  input logic             ALU_flush,
  alu_seq_muldiv_if.slave bus
);
  localparam int M = WIDTH - 1;

  state_t r_state;
  state_t w_next;

  logic [3:0]       w_ctrl;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_iter_op;
  logic             w_accept;
  logic             w_start;
  logic             w_load;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_f_res;
  logic [WIDTH-1:0] w_f_hi;
  logic             w_f_c;
  logic             w_f_v;
  logic             w_f_dz;
  logic             w_f_il;

  logic             w_it_done;
  logic [WIDTH-1:0] w_it_lo;
  logic [WIDTH-1:0] w_it_hi;

  logic [WIDTH-1:0] w_n_res;
  logic [WIDTH-1:0] w_n_hi;
  logic [7:0]       w_n_st;

  logic             r_is_div;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_hi;
  logic [7:0]       r_st;

  assign w_ctrl = bus.ALU_ctrl;
  assign w_a    = bus.ALU_operand_1;
  assign w_b    = bus.ALU_operand_2;

  // divide by zero short-circuits to a one-cycle op
  assign w_iter_op = (w_ctrl == ALU_MULTU)
                   || ((w_ctrl == ALU_DIVU) && |w_b);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state; flush beats every other condition
  always_comb begin
    w_next = r_state;
    if (ALU_flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:
          if (bus.in_valid)
            w_next = w_iter_op ? S_BUSY : S_DONE;
        S_BUSY:
          if (w_it_done) w_next = S_DONE;
        S_DONE:
          if (bus.out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // handshake and datapath control
  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
    w_accept = (r_state == S_IDLE)
             && bus.in_valid && !ALU_flush;
    w_start  = w_accept && w_iter_op;
    w_load   = (w_accept && !w_iter_op)
             || ((r_state == S_BUSY)
                 && w_it_done && !ALU_flush);
  end

  // single-cycle ops, divide-by-zero and illegal codes
  always_comb begin
    w_sum   = {1'b0, w_a} + {1'b0, w_b};
    w_diff  = {1'b0, w_a} - {1'b0, w_b};
    w_f_res = '0;
    w_f_hi  = '0;
    w_f_c   = 1'b0;
    w_f_v   = 1'b0;
    w_f_dz  = 1'b0;
    w_f_il  = 1'b0;
    unique case (1'b1)
      (w_ctrl == ALU_ADD): begin
        w_f_res = w_sum[M:0];
        w_f_c   = w_sum[WIDTH];
        w_f_v   = (w_a[M] == w_b[M])
                && (w_sum[M] != w_a[M]);
      end
      (w_ctrl == ALU_SUB): begin
        w_f_res = w_diff[M:0];
        w_f_c   = w_diff[WIDTH];
        w_f_v   = (w_a[M] != w_b[M])
                && (w_diff[M] != w_a[M]);
      end
      (w_ctrl == ALU_AND): w_f_res = w_a & w_b;
      (w_ctrl == ALU_OR):  w_f_res = w_a | w_b;
      (w_ctrl == ALU_NOR): w_f_res = ~(w_a | w_b);
      (w_ctrl == ALU_SLT):
        w_f_res[0] = $signed(w_a) < $signed(w_b);
      (w_ctrl == ALU_DIVU): begin
        w_f_res = '1;
        w_f_hi  = w_a;
        w_f_dz  = 1'b1;
      end
      (w_ctrl == ALU_MULTU): begin
      end
      default: w_f_il = 1'b1;
    endcase
  end

  // pick the value that lands in the output registers
  always_comb begin
    w_n_st = '0;
    if (r_state == S_BUSY) begin
      w_n_res = w_it_lo;
      w_n_hi  = w_it_hi;
      w_n_st[ST_ZERO] = (w_it_lo == '0)
                     && (r_is_div || (w_it_hi == '0));
    end else begin
      w_n_res = w_f_res;
      w_n_hi  = w_f_hi;
      w_n_st[ST_ZERO]  = (w_f_res == '0);
      w_n_st[ST_CARRY] = w_f_c;
      w_n_st[ST_OVF]   = w_f_v;
      w_n_st[ST_DIVZ]  = w_f_dz;
      w_n_st[ST_ILL]   = w_f_il;
    end
    w_n_st[ST_NEG] = w_n_res[M];
  end

  // remember which iterative op is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_is_div <= 1'b0;
    else if (w_start) r_is_div <= (w_ctrl == ALU_DIVU);
  end

  // result/flags update only on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
      r_hi  <= '0;
      r_st  <= '0;
    end else if (w_load) begin
      r_res <= w_n_res;
      r_hi  <= w_n_hi;
      r_st  <= w_n_st;
    end
  end

  assign bus.ALU_result    = r_res;
  assign bus.ALU_result_hi = r_hi;
  assign bus.ALU_status    = r_st;

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_abort (ALU_flush),
    .i_div   (w_ctrl == ALU_DIVU),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_done  (w_it_done),
    .o_lo    (w_it_lo),
    .o_hi    (w_it_hi)
  );
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// alu_seq_muldiv bench: directed plan steps plus
// random ops against an arithmetic reference model.
module tb_alu_seq_muldiv;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [31:0] last_r = '0;
  logic [31:0] last_h = '0;
  logic [7:0]  last_s = '0;

  always #5 clk = ~clk;

  alu_seq_muldiv_if #(.WIDTH(32)) bus ();

  alu_seq_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ALU_flush (flush),
    .bus       (bus.slave)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic void model(
    input  logic [3:0]  c,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic [31:0] h,
    output logic [7:0]  s,
    output int          lat);
    longint sa, sb, t, lim;
    longint unsigned ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    lim = 64'sd2147483647;
    r = '0; h = '0; s = '0; lat = 1;
    case (c)
      4'b0010: begin
        t = sa + sb; r = a + b;
        s[2] = (ua + ub) > 64'hFFFF_FFFF;
        s[3] = (t > lim) || (t < -lim - 1);
      end
      4'b0110: begin
        t = sa - sb; r = a - b;
        s[2] = a < b;
        s[3] = (t > lim) || (t < -lim - 1);
      end
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: begin
        p = ua * ub;
        r = p[31:0]; h = p[63:32]; lat = 33;
      end
      4'b1001: begin
        if (b == 0) begin
          r = 32'hFFFF_FFFF; h = a; s[4] = 1'b1;
        end else begin
          r = a / b; h = a % b; lat = 33;
        end
      end
      default: s[5] = 1'b1;
    endcase
    s[0] = (r == 0) && (c != 4'b1000 || h == 0);
    s[1] = r[31];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0]  c,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int          hold);
    logic [31:0] er, eh;
    logic [7:0]  es;
    int el, lat;
    model(c, a, b, er, eh, es, el);
    lat = 0;
    while (!bus.in_ready && lat < 100) begin
      tick(); lat++;
    end
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.ALU_ctrl = c;
    bus.ALU_operand_1 = a;
    bus.ALU_operand_2 = b;
    tick();
    bus.in_valid = 1'b0;
    bus.ALU_ctrl = 4'($urandom);
    bus.ALU_operand_1 = $urandom;
    bus.ALU_operand_2 = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      chk("in_ready_busy", bus.in_ready, 0);
      chk("hold_busy", bus.ALU_result, last_r);
      tick(); lat++;
    end
    chk("latency", lat, el);
    chk("result", bus.ALU_result, er);
    chk("result_hi", bus.ALU_result_hi, eh);
    chk("status", bus.ALU_status, es);
    chk("in_ready_done", bus.in_ready, 0);
    repeat (hold) begin
      tick();
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_result", bus.ALU_result, er);
      chk("bp_hi", bus.ALU_result_hi, eh);
      chk("bp_status", bus.ALU_status, es);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("drain_valid", bus.out_valid, 0);
    chk("drain_in_ready", bus.in_ready, 1);
    chk("idle_hold", bus.ALU_result, er);
    last_r = er; last_h = eh; last_s = es;
  endtask

  task automatic no_valid_for(input string tag,
                              input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    logic [3:0] codes [11];
    logic [3:0] c;
    logic [31:0] a, b;
    codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
              4'b0111, 4'b1100, 4'b1000, 4'b1001,
              4'b0011, 4'b1010, 4'b1111};
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.ALU_ctrl = '0;
    bus.ALU_operand_1 = '0;
    bus.ALU_operand_2 = '0;
    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.ALU_result, 0);
    chk("rst_hi", bus.ALU_result_hi, 0);
    chk("rst_status", bus.ALU_status, 0);
    tick();
    rst_n = 1'b1;
    tick();

    do_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
    do_op(4'b0110, 32'd5, 32'd7, 0);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'b1100, 32'd0, 32'd0, 0);
    do_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(4'b1001, 32'd100, 32'd7, 5);
    do_op(4'b1001, 32'd9, 32'd0, 0);

    // flush at cycle 10 of a MULTU
    bus.in_valid = 1'b1;
    bus.ALU_ctrl = 4'b1000;
    bus.ALU_operand_1 = 32'h1234_5678;
    bus.ALU_operand_2 = 32'h9ABC_DEF0;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    chk("flush_hold", bus.ALU_result, last_r);
    chk("flush_hold_hi", bus.ALU_result_hi, last_h);
    chk("flush_hold_st", bus.ALU_status, last_s);
    no_valid_for("flush_no_valid", 40);

    // flush wins over a same-cycle request
    bus.in_valid = 1'b1;
    bus.ALU_ctrl = 4'b0010;
    flush = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_acc_ready", bus.in_ready, 1);
    no_valid_for("flush_acc_valid", 3);

    // async reset in the middle of a DIVU
    bus.in_valid = 1'b1;
    bus.ALU_ctrl = 4'b1001;
    bus.ALU_operand_1 = 32'd1000;
    bus.ALU_operand_2 = 32'd3;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_in_ready", bus.in_ready, 1);
    chk("mrst_result", bus.ALU_result, 0);
    chk("mrst_hi", bus.ALU_result_hi, 0);
    chk("mrst_status", bus.ALU_status, 0);
    #1;
    rst_n = 1'b1;
    last_r = '0; last_h = '0; last_s = '0;
    no_valid_for("mrst_no_valid", 40);

    do_op(4'b0010, 32'd2, 32'd3, 0);
    chk("add_2_3", last_r, 32'd5);
    do_op(4'b1111, 32'hDEAD_BEEF, 32'h1, 0);

    for (int i = 0; i < 40; i++) begin
      c = codes[$urandom_range(0, 10)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = a >> 24;
      if ($urandom_range(0, 3) == 0) b = b >> 20;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      do_op(c, a, b, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
